// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: configuration constants, entry and CDB
// port structs, wrap-bit pointer type and a small port-index width helper.
// Pure declarations; no logic, no latency, no flow control.
package rob_pkg;

  // Build-time configuration. The storage and CDB structs are sized from these,
  // so the top-level parameters default to them and must stay in step.
  localparam int ROB_SIZE_CFG   = 16;
  localparam int TAG_W_CFG      = $clog2(ROB_SIZE_CFG);
  localparam int DATA_WIDTH_CFG = 32;
  localparam int REG_WIDTH_CFG  = 5;
  localparam int NUM_CDB_CFG    = 2;

  // Pointer carries one extra MSB (wrap bit) so full and empty are distinct.
  typedef logic [TAG_W_CFG:0] ptr_t;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic [REG_WIDTH_CFG-1:0]  dest_reg;
    logic [DATA_WIDTH_CFG-1:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic                      valid;
    logic [TAG_W_CFG-1:0]      tag;
    logic [DATA_WIDTH_CFG-1:0] data;
  } cdb_port_t;

  // Width of a CDB port index; a single port still needs a 1-bit field.
  function automatic int cdb_port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/rob_cdb_match.sv
// Purpose : finds the CDB port broadcasting a given tag (highest port index wins).
// Latency : purely combinational.
// Backpres: none; observes the broadcast bus only.
// Ports   : cdb (unpacked per-port valid/tag/data), tag (tag to search for),
//           hit (some valid port carries tag), data (winning port's data),
//           port (winning port index).
module rob_cdb_match
  import rob_pkg::*;
#(
  parameter int  NUM_CDB = NUM_CDB_CFG,
  localparam int PORT_W  = cdb_port_w(NUM_CDB)
) (
  input  cdb_port_t                 cdb [NUM_CDB],
  input  logic [TAG_W_CFG-1:0]      tag,
  output logic                      hit,
  output logic [DATA_WIDTH_CFG-1:0] data,
  output logic [PORT_W-1:0]         port
);

  // Ascending scan: a later (higher) port overwrites an earlier match.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    port = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb[p].valid && (cdb[p].tag == tag)) begin
        hit  = 1'b1;
        data = cdb[p].data;
        port = PORT_W'(p);
      end
    end
  end

endmodule

// File: rtl/rob_circular.sv
// Purpose : circular reorder buffer; in-order alloc at tail, out-of-order CDB
//           completion, in-order commit at head, two bypassed operand lookups.
// Latency : alloc_tag/commit_*/lookup_* are combinational; state updates next edge.
// Backpres: alloc_ready = ~full & ~flush; commit waits on commit_ready.
// Ports   : clk/rst (sync, active-high), flush; alloc_valid/ready/dest_reg/tag;
//           cdb_valid/tag/data (NUM_CDB packed ports); lookup_tag/ready/data (2);
//           commit_valid/ready/tag/dest_reg/data; count/full/empty status.
module rob_circular
  import rob_pkg::*;
#(
  parameter int  ROB_SIZE   = ROB_SIZE_CFG,
  parameter int  DATA_WIDTH = DATA_WIDTH_CFG,
  parameter int  REG_WIDTH  = REG_WIDTH_CFG,
  parameter int  NUM_CDB    = NUM_CDB_CFG,
  localparam int TAG_WIDTH  = $clog2(ROB_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [REG_WIDTH-1:0]          alloc_dest_reg,
  output logic [TAG_WIDTH-1:0]          alloc_tag,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*TAG_WIDTH-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_WIDTH-1:0] cdb_data,
  input  logic [2*TAG_WIDTH-1:0]        lookup_tag,
  output logic [1:0]                    lookup_ready,
  output logic [2*DATA_WIDTH-1:0]       lookup_data,
  output logic                          commit_valid,
  input  logic                          commit_ready,
  output logic [TAG_WIDTH-1:0]          commit_tag,
  output logic [REG_WIDTH-1:0]          commit_dest_reg,
  output logic [DATA_WIDTH-1:0]         commit_data,
  output logic [TAG_WIDTH:0]            count,
  output logic                          full,
  output logic                          empty
);

  localparam int PORT_W = cdb_port_w(NUM_CDB);

  rob_entry_t ent [ROB_SIZE];
  ptr_t       head;
  ptr_t       tail;
  cdb_port_t  cdb [NUM_CDB];

  logic [TAG_WIDTH-1:0]  head_idx;
  logic [TAG_WIDTH-1:0]  tail_idx;
  logic                  alloc_fire;
  logic                  commit_fire;
  logic                  cdb_we    [ROB_SIZE];
  logic [DATA_WIDTH-1:0] cdb_wdata [ROB_SIZE];

  assign head_idx = head[TAG_WIDTH-1:0];
  assign tail_idx = tail[TAG_WIDTH-1:0];

  always_comb begin
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb[p].valid = cdb_valid[p];
      cdb[p].tag   = cdb_tag[p*TAG_WIDTH +: TAG_WIDTH];
      cdb[p].data  = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Occupancy straight from the pointers; modulo arithmetic handles wrap.
  assign count = tail - head;
  assign empty = (head == tail);
  assign full  = (head_idx == tail_idx) && (head[TAG_WIDTH] != tail[TAG_WIDTH]);

  // No same-cycle slot reuse: a full ROB refuses alloc even if head commits.
  assign alloc_ready = ~full & ~flush;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign commit_valid    = ent[head_idx].valid & ent[head_idx].done;
  assign commit_tag      = head_idx;
  assign commit_dest_reg = ent[head_idx].dest_reg;
  assign commit_data     = ent[head_idx].data;
  assign commit_fire     = commit_valid & commit_ready;

  // Per-entry write-enable decode. The entry being allocated this cycle is
  // still invalid, so a CDB hit on it is dropped by the valid qualifier.
  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_wr
    logic              hit;
    logic [PORT_W-1:0] win;
    logic              dup;

    rob_cdb_match #(.NUM_CDB(NUM_CDB)) u_match (
      .cdb  (cdb),
      .tag  (TAG_WIDTH'(i)),
      .hit  (hit),
      .data (cdb_wdata[i]),
      .port (win)
    );

    assign cdb_we[i] = hit & ent[i].valid & ~ent[i].done;

    // Any matching port other than the winner means two ports share a tag.
    always_comb begin
      dup = 1'b0;
      for (int p = 0; p < NUM_CDB; p++) begin
        if (cdb[p].valid && (cdb[p].tag == TAG_WIDTH'(i)) && (PORT_W'(p) != win)) begin
          dup = 1'b1;
        end
      end
    end

    a_no_dup_tag: assert property (@(posedge clk) disable iff (rst) !dup)
      else $error("two CDB ports broadcast tag %0d in one cycle", i);
  end

  // Operand lookup: a live broadcast beats stored state.
  for (genvar j = 0; j < 2; j++) begin : g_lk
    logic [TAG_WIDTH-1:0]  ltag;
    logic                  hit;
    logic [DATA_WIDTH-1:0] bdata;
    logic [PORT_W-1:0]     win;

    assign ltag = lookup_tag[j*TAG_WIDTH +: TAG_WIDTH];

    rob_cdb_match #(.NUM_CDB(NUM_CDB)) u_match (
      .cdb  (cdb),
      .tag  (ltag),
      .hit  (hit),
      .data (bdata),
      .port (win)
    );

    assign lookup_ready[j] = hit | (ent[ltag].valid & ent[ltag].done);
    assign lookup_data[j*DATA_WIDTH +: DATA_WIDTH] = hit ? bdata : ent[ltag].data;

    a_bypass_live: assert property (@(posedge clk) disable iff (rst) !hit || cdb_valid[win]);
  end

  // Flush shares the reset path so it overrides alloc, commit and CDB.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (cdb_we[i]) begin
          ent[i].done <= 1'b1;
          ent[i].data <= cdb_wdata[i];
        end
      end
      if (commit_fire) begin
        ent[head_idx].valid <= 1'b0;
        head                <= ptr_inc(head);
      end
      if (alloc_fire) begin
        ent[tail_idx].valid    <= 1'b1;
        ent[tail_idx].done     <= 1'b0;
        ent[tail_idx].dest_reg <= alloc_dest_reg;
        tail                   <= ptr_inc(tail);
      end
    end
  end

endmodule

// File: tb/tb_rob_circular.sv
module tb_rob_circular;

  localparam int N  = 16;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int NC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [RW-1:0]   alloc_dest_reg;
  logic [TW-1:0]   alloc_tag;
  logic [NC-1:0]   cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*DW-1:0] cdb_data;
  logic [2*TW-1:0] lookup_tag;
  logic [1:0]      lookup_ready;
  logic [2*DW-1:0] lookup_data;
  logic            commit_valid;
  logic            commit_ready;
  logic [TW-1:0]   commit_tag;
  logic [RW-1:0]   commit_dest_reg;
  logic [DW-1:0]   commit_data;
  logic [TW:0]     count;
  logic            full;
  logic            empty;

  always #5 clk = ~clk;

  rob_circular dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_dest_reg  (alloc_dest_reg),
    .alloc_tag       (alloc_tag),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .lookup_tag      (lookup_tag),
    .lookup_ready    (lookup_ready),
    .lookup_data     (lookup_data),
    .commit_valid    (commit_valid),
    .commit_ready    (commit_ready),
    .commit_tag      (commit_tag),
    .commit_dest_reg (commit_dest_reg),
    .commit_data     (commit_data),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: in-flight instructions tracked by absolute sequence
  // numbers; the ROB slot of sequence s is s mod N.
  bit          m_v    [N];
  bit          m_d    [N];
  int          m_dest [N];
  logic [31:0] m_data [N];
  int          m_head;
  int          m_tail;

  function automatic int m_count();
    return m_tail - m_head;
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_tail = 0;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    rst            = 1'b0;
    flush          = 1'b0;
    alloc_valid    = 1'b0;
    alloc_dest_reg = '0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    cdb_data       = '0;
    lookup_tag     = '0;
    commit_ready   = 1'b0;
  endtask

  task automatic set_cdb(input int p, input int t, input logic [31:0] d);
    cdb_valid[p]          = 1'b1;
    cdb_tag[p*TW +: TW]   = TW'(t);
    cdb_data[p*DW +: DW]  = d;
  endtask

  task automatic set_lookup(input int j, input int t);
    lookup_tag[j*TW +: TW] = TW'(t);
  endtask

  // Compare every observable output against what the model predicts for the
  // currently driven inputs.
  task automatic check_outputs();
    int h, c, lt;
    bit cv, hit, rdy;
    logic [31:0] d;
    c = m_count();
    h = m_head % N;
    check_val("count", count, c);
    check_val("full", full, c == N);
    check_val("empty", empty, c == 0);
    check_val("alloc_ready", alloc_ready, (c != N) && !flush);
    check_val("alloc_tag", alloc_tag, m_tail % N);
    cv = m_v[h] && m_d[h];
    check_val("commit_valid", commit_valid, cv);
    if (cv) begin
      check_val("commit_tag", commit_tag, h);
      check_val("commit_dest_reg", commit_dest_reg, m_dest[h]);
      check_val("commit_data", commit_data, m_data[h]);
    end
    for (int j = 0; j < 2; j++) begin
      lt  = int'(lookup_tag[j*TW +: TW]);
      hit = 1'b0;
      d   = '0;
      for (int p = 0; p < NC; p++) begin
        if (cdb_valid[p] && int'(cdb_tag[p*TW +: TW]) == lt) begin
          hit = 1'b1;
          d   = cdb_data[p*DW +: DW];
        end
      end
      rdy = hit || (m_v[lt] && m_d[lt]);
      if (!hit) d = m_data[lt];
      check_val($sformatf("lookup_ready%0d", j), lookup_ready[j], rdy);
      if (rdy) check_val($sformatf("lookup_data%0d", j), lookup_data[j*DW +: DW], d);
    end
  endtask

  task automatic model_edge();
    bit pv [N];
    bit pd [N];
    int t, h;
    if (rst || flush) begin
      model_reset();
      return;
    end
    pv = m_v;
    pd = m_d;
    for (int p = 0; p < NC; p++) begin
      t = int'(cdb_tag[p*TW +: TW]);
      if (cdb_valid[p] && pv[t] && !pd[t]) begin
        m_d[t]    = 1'b1;
        m_data[t] = cdb_data[p*DW +: DW];
      end
    end
    h = m_head % N;
    if (pv[h] && pd[h] && commit_ready) begin
      m_v[h] = 1'b0;
      m_head++;
    end
    if (alloc_valid && (m_tail - m_head + (pv[h] && pd[h] && commit_ready ? 1 : 0)) != N) begin
      t         = m_tail % N;
      m_v[t]    = 1'b1;
      m_d[t]    = 1'b0;
      m_dest[t] = int'(alloc_dest_reg);
      m_tail++;
    end
  endtask

  // Inputs are driven after a falling edge; check, take the rising edge, update
  // the model, then return at the next falling edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic random_cycle();
    int q[$];
    int t0;
    clear_inputs();
    alloc_valid    = ($urandom % 4) != 0;
    alloc_dest_reg = RW'($urandom);
    commit_ready   = ($urandom % 4) != 0;
    for (int t = 0; t < N; t++) if (m_v[t] && !m_d[t]) q.push_back(t);
    t0 = -1;
    for (int p = 0; p < NC; p++) begin
      int t;
      if (($urandom % 3) == 0) continue;
      if (q.size() > 0 && ($urandom % 4) != 0) t = q[$urandom_range(q.size() - 1)];
      else t = int'($urandom_range(N - 1));
      if (t == t0) continue;
      set_cdb(p, t, $urandom);
      t0 = t;
    end
    for (int j = 0; j < 2; j++) begin
      if (t0 >= 0 && ($urandom % 3) == 0) set_lookup(j, t0);
      else set_lookup(j, int'($urandom_range(N - 1)));
    end
    flush = ($urandom % 64) == 0;
    rst   = ($urandom % 300) == 0;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset state.
    clear_inputs();
    #1;
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_count", count, 0);
    check_val("rst_alloc_ready", alloc_ready, 1);
    check_val("rst_commit_valid", commit_valid, 0);
    check_val("rst_lookup_ready", lookup_ready, 0);
    tick();

    // Fill: dest_reg 1..16 receives tags 0..15.
    for (int k = 1; k <= N; k++) begin
      clear_inputs();
      alloc_valid    = 1'b1;
      alloc_dest_reg = RW'(k);
      #1;
      check_val("fill_alloc_tag", alloc_tag, k - 1);
      tick();
    end
    clear_inputs();
    alloc_valid  = 1'b1;
    commit_ready = 1'b1;
    #1;
    check_val("fill_full", full, 1);
    check_val("fill_alloc_ready", alloc_ready, 0);
    check_val("fill_count", count, 16);
    tick();

    // Out-of-order completion: tag 3 first must not release the head.
    clear_inputs();
    set_cdb(0, 3, 32'hAA);
    tick();
    clear_inputs();
    commit_ready = 1'b1;
    #1;
    check_val("ooo_no_commit", commit_valid, 0);
    tick();
    clear_inputs();
    set_cdb(0, 0, 32'h11);
    tick();
    clear_inputs();
    #1;
    check_val("head_commit_valid", commit_valid, 1);
    check_val("head_commit_tag", commit_tag, 0);
    check_val("head_commit_data", commit_data, 32'h11);
    tick();

    // Same-cycle bypass, then the stored value.
    clear_inputs();
    set_cdb(1, 5, 32'hDEAD);
    set_lookup(0, 5);
    #1;
    check_val("bypass_ready", lookup_ready[0], 1);
    check_val("bypass_data", lookup_data[DW-1:0], 32'hDEAD);
    tick();
    clear_inputs();
    set_lookup(0, 5);
    #1;
    check_val("stored_ready", lookup_ready[0], 1);
    check_val("stored_data", lookup_data[DW-1:0], 32'hDEAD);
    tick();

    // A second completion of an already-done entry is ignored.
    clear_inputs();
    set_cdb(0, 5, 32'hBAD);
    tick();

    clear_inputs();
    set_cdb(0, 1, 32'h22);
    set_cdb(1, 2, 32'h33);
    tick();
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      commit_ready = 1'b1;
      set_lookup(1, 5);
      #1;
      check_val("inorder_commit_tag", commit_tag, k);
      tick();
    end

    for (int t = 4; t < N; t++) begin
      clear_inputs();
      set_cdb(0, t, $urandom);
      tick();
    end

    // Steady state: one alloc and one commit per cycle, pointers wrap.
    for (int k = 0; k < 40; k++) begin
      int last;
      clear_inputs();
      alloc_valid    = 1'b1;
      alloc_dest_reg = RW'($urandom);
      commit_ready   = 1'b1;
      last = (m_tail - 1) % N;
      if (m_v[last] && !m_d[last]) set_cdb(0, last, $urandom);
      set_lookup(0, int'($urandom_range(N - 1)));
      set_lookup(1, int'($urandom_range(N - 1)));
      #1;
      check_val("steady_count", count, 12);
      check_val("steady_commit_tag", commit_tag, (4 + k) % N);
      tick();
    end

    // Drain to 7, then flush against alloc/CDB/commit.
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      commit_ready = 1'b1;
      tick();
    end
    clear_inputs();
    flush        = 1'b1;
    alloc_valid  = 1'b1;
    commit_ready = 1'b1;
    set_cdb(0, (m_tail - 1) % N, 32'h5A5A);
    #1;
    check_val("preflush_count", count, 7);
    tick();
    clear_inputs();
    #1;
    check_val("flush_count", count, 0);
    check_val("flush_empty", empty, 1);
    check_val("flush_commit_valid", commit_valid, 0);
    check_val("flush_alloc_tag", alloc_tag, 0);

    // Nine entries, then reset alongside a pending completion.
    for (int k = 0; k < 9; k++) begin
      clear_inputs();
      alloc_valid    = 1'b1;
      alloc_dest_reg = RW'(k);
      tick();
    end
    clear_inputs();
    rst = 1'b1;
    set_cdb(0, 2, 32'h77);
    #1;
    check_val("prerst_count", count, 9);
    tick();
    clear_inputs();
    #1;
    check_val("midrst_count", count, 0);
    check_val("midrst_empty", empty, 1);
    check_val("midrst_full", full, 0);
    check_val("midrst_alloc_ready", alloc_ready, 1);
    check_val("midrst_commit_valid", commit_valid, 0);
    check_val("midrst_lookup_ready", lookup_ready, 0);
    clear_inputs();
    set_cdb(0, 2, 32'h99);
    tick();
    clear_inputs();
    set_lookup(0, 2);
    #1;
    check_val("stale_tag_ignored", lookup_ready[0], 0);
    tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) random_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
